hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Central hazard controller for the 5-stage pipelined MIPS core. It generates the
//  stall/flush controls for the IF/ID register, the PC write enable, the ID/EX bubble
//  and a whole-pipeline freeze during data-memory wait states.
//  It tracks memory-wait state for a timeout watchdog and keeps saturating
//  stall/flush performance counters. It sits beside the ID stage, where branches resolve.
// PARAMETERS
//  MEM_TIMEOUT  64  consecutive MEM_WAIT cycles before mem_timeout is raised
//  CNT_W        16  width of the performance counters
// PORTS
//  clock          in   1      pipeline clock, rising edge
//  reset          in   1      asynchronous, active-low
//  ifid_inst      in   32     IF/ID instruction; rs=[25:21], rt=[20:16], op=[31:26]
//  id_uses_rt     in   1      ID instruction reads rt as a source (R-type, beq, sw)
//  id_is_branch   in   1      ID instruction is beq/bne (compared in ID)
//  branch_taken   in   1      ID branch/jump resolved taken this cycle
//  idex_regwrite  in   1      ID/EX instruction writes a register
//  idex_memread   in   1      ID/EX instruction is a load
//  idex_dst       in   5      ID/EX destination register
//  exmem_memread  in   1      EX/MEM instruction is a load
//  exmem_dst      in   5      EX/MEM destination register
//  exmem_memacc   in   1      EX/MEM instruction accesses data memory (lw/sw)
//  dmem_ready     in   1      data memory completes the access this cycle
//  pc_write       out  1      PC load enable
//  ifid_stall     out  1      hold IF/ID
//  ifid_flush     out  1      zero the IF/ID instruction (PC+4 still passes)
//  idex_bubble    out  1      load a NOP into ID/EX
//  pipe_freeze    out  1      hold ID/EX, EX/MEM and MEM/WB
//  mem_timeout    out  1      sticky watchdog flag
//  stall_cycles   out  CNT_W  cycles with ifid_stall=1, saturating
//  flush_count    out  CNT_W  cycles with ifid_flush=1, saturating
// BEHAVIOUR
//  - Registered state: fsm {RUN, MEM_WAIT}, wait_cnt, mem_timeout, both counters.
//    All other outputs are combinational from the state and the inputs.
//  - Reset (async, any time, including mid-wait): fsm=RUN, wait_cnt=0, mem_timeout=0,
//    counters=0. With reset asserted: pc_write=1; ifid_stall, ifid_flush, idex_bubble,
//    pipe_freeze = 0.
//  - Register 0 never creates a hazard. A match means dst!=0 and dst==rs, or
//    (id_uses_rt and dst==rt).
//  - mem_stall = exmem_memacc & ~dmem_ready.
//    While mem_stall: pipe_freeze=1, ifid_stall=1, pc_write=0, idex_bubble=0, ifid_flush=0.
//  - Otherwise, hazard stall hz is any of:
//    (a) idex_memread and a match on idex_dst (load-use);
//    (b) id_is_branch, idex_regwrite and a match on idex_dst;
//    (c) id_is_branch, exmem_memread and a match on exmem_dst.
//    hz gives ifid_stall=1, pc_write=0, idex_bubble=1.
//    A load feeding a branch therefore stalls 2 cycles: (b), then (c).
//  - Flush: ifid_flush = branch_taken & ~hz & ~mem_stall. A branch is only acted on when
//    its operands are valid. ifid_flush and ifid_stall are never both 1; the controller
//    relies on IF/ID giving flush priority over stall. pc_write stays 1 on a flush.
//  - FSM:
//    RUN -> MEM_WAIT when mem_stall; wait_cnt=1.
//    MEM_WAIT: wait_cnt increments, saturating at MEM_TIMEOUT.
//    When wait_cnt==MEM_TIMEOUT, mem_timeout<=1 (sticky until reset). The pipeline keeps
//    waiting; there is no abort.
//    MEM_WAIT -> RUN on the first cycle with dmem_ready=1; wait_cnt=0. That cycle is
//    not frozen.
//    A dmem_ready and a new access on the same cycle end the old wait only.
//  - Counters increment on each clock edge where the respective output is 1, and hold
//    at all-ones.
// TESTING
//  1 lw $2 in ID/EX (idex_memread=1, idex_dst=2), add $3,$2,$4 in ID
//    -> one cycle of ifid_stall=1, pc_write=0, idex_bubble=1; stall_cycles=1.
//  2 lw $5 then beq $5,$0: cycle1 rule (b), cycle2 rule (c)
//    -> exactly 2 stall cycles, then ifid_flush=1 when branch_taken=1; flush_count=1.
//  3 dst=0 with an otherwise matching load -> no stall; pc_write stays 1.
//  4 exmem_memacc=1, dmem_ready=0 for 3 cycles -> pipe_freeze=1 for 3 cycles.
//    A branch_taken during the freeze gives no flush. Release cycle: fsm=RUN, freeze=0.
//  5 MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles -> mem_timeout=1 from the 4th wait
//    cycle; still 1 after dmem_ready returns.
//  6 Assert reset mid-MEM_WAIT with counters nonzero -> all registered state 0 at once;
//    pc_write=1. The first cycle after release behaves as RUN.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and branch-operand stalls,
// taken-branch flush, data-memory freeze with a sticky timeout watchdog and perf counters.
module hazard_ctrl_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ifid_inst,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             idex_regwrite,
  input  logic             idex_memread,
  input  logic [4:0]       idex_dst,
  input  logic             exmem_memread,
  input  logic [4:0]       exmem_dst,
  input  logic             exmem_memacc,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [4:0] rs, rt;
  logic       mem_stall, hz;
  logic       unused_inst_bits;

  assign rs = ifid_inst[25:21];
  assign rt = ifid_inst[20:16];
  assign unused_inst_bits = &{1'b0, ifid_inst[31:26], ifid_inst[15:0]};

  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src_s,
                                     input logic [4:0] src_t, input logic uses_t);
    return (dst != '0) && ((dst == src_s) || (uses_t && (dst == src_t)));
  endfunction

  assign mem_stall = exmem_memacc & ~dmem_ready;

  always_comb begin
    hz = 1'b0;
    if (idex_memread && reg_match(idex_dst, rs, rt, id_uses_rt))
      hz = 1'b1;
    if (id_is_branch && idex_regwrite && reg_match(idex_dst, rs, rt, id_uses_rt))
      hz = 1'b1;
    if (id_is_branch && exmem_memread && reg_match(exmem_dst, rs, rt, id_uses_rt))
      hz = 1'b1;
  end

  // Pipeline controls are forced to their idle values while reset is held, even mid-cycle.
  always_comb begin
    pc_write    = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        pipe_freeze = 1'b1;
        ifid_stall  = 1'b1;
        pc_write    = 1'b0;
      end else if (hz) begin
        ifid_stall  = 1'b1;
        pc_write    = 1'b0;
        idex_bubble = 1'b1;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WC_MAX) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q | (wait_cnt_d == WC_MAX);
    stall_d   = (ifid_stall && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d   = (ifid_flush && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   ifid_inst;
  logic          id_uses_rt, id_is_branch, branch_taken;
  logic          idex_regwrite, idex_memread;
  logic [4:0]    idex_dst;
  logic          exmem_memread;
  logic [4:0]    exmem_dst;
  logic          exmem_memacc, dmem_ready;
  logic          pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .ifid_inst(ifid_inst),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_dst(idex_dst),
    .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
    .exmem_memacc(exmem_memacc), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, br, taken, idex_rw, idex_mr;
    logic [4:0] idex_d;
    logic       ex_mr;
    logic [4:0] ex_d;
    logic       memacc, rdy;
  } vec_t;

  // flags = {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}
  localparam logic [5:0] IDLE  = 6'b100000;
  localparam logic [5:0] HZ    = 6'b010100;
  localparam logic [5:0] FLUSH = 6'b101000;
  localparam logic [5:0] FRZ   = 6'b010010;
  localparam logic [5:0] ALL   = 6'b111111;
  localparam logic [5:0] NO_TO = 6'b111110;

  string      nq[$];
  logic [5:0] fq[$];
  logic [5:0] mq[$];
  int         sq[$];
  int         cq[$];

  int checks = 0;
  int failures = 0;

  function automatic vec_t idle_vec();
    vec_t v;
    v.rst = 1'b1; v.rs = '0; v.rt = '0; v.uses_rt = 1'b0; v.br = 1'b0; v.taken = 1'b0;
    v.idex_rw = 1'b0; v.idex_mr = 1'b0; v.idex_d = '0; v.ex_mr = 1'b0; v.ex_d = '0;
    v.memacc = 1'b0; v.rdy = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    ifid_inst     = {6'b000100, v.rs, v.rt, 16'h1234};
    id_uses_rt    = v.uses_rt;
    id_is_branch  = v.br;
    branch_taken  = v.taken;
    idex_regwrite = v.idex_rw;
    idex_memread  = v.idex_mr;
    idex_dst      = v.idex_d;
    exmem_memread = v.ex_mr;
    exmem_dst     = v.ex_d;
    exmem_memacc  = v.memacc;
    dmem_ready    = v.rdy;
  endtask

  task automatic cyc(input vec_t v, input string nm, input logic [5:0] fl,
                     input logic [5:0] mk, input int sc, input int fc);
    @(posedge clock);
    #1;
    drive(v);
    nq.push_back(nm); fq.push_back(fl); mq.push_back(mk);
    sq.push_back(sc); cq.push_back(fc);
  endtask

  always @(negedge clock) begin
    if (fq.size() != 0) begin
      string      nm;
      logic [5:0] fl, mk, got;
      int         sc, fc;
      nm = nq.pop_front(); fl = fq.pop_front(); mk = mq.pop_front();
      sc = sq.pop_front(); fc = cq.pop_front();
      got = {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_timeout};
      checks++;
      if ((((got ^ fl) & mk) != '0) || (int'(stall_cycles) != sc) || (int'(flush_count) != fc)) begin
        failures++;
        $display("FAIL %s: got flags=%b stall=%0d flush=%0d, expected flags=%b (mask %b) stall=%0d flush=%0d",
                 nm, got, stall_cycles, flush_count, fl, mk, sc, fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    v = idle_vec(); v.rst = 1'b0;
    drive(v);

    // reset held with stall-provoking inputs: controls stay idle
    v = idle_vec(); v.rst = 1'b0; v.memacc = 1'b1; v.rdy = 1'b0;
    v.idex_mr = 1'b1; v.idex_d = 5'd2; v.rs = 5'd2;
    cyc(v, "reset_hold", IDLE, ALL, 0, 0);
    cyc(idle_vec(), "reset_release", IDLE, ALL, 0, 0);

    // load-use on rs, then on rt
    v = idle_vec(); v.idex_mr = 1'b1; v.idex_d = 5'd2; v.rs = 5'd2; v.rt = 5'd4; v.uses_rt = 1'b1;
    cyc(v, "loaduse_rs", HZ, ALL, 0, 0);
    cyc(idle_vec(), "after_loaduse", IDLE, ALL, 1, 0);
    v = idle_vec(); v.idex_mr = 1'b1; v.idex_d = 5'd4; v.rs = 5'd2; v.rt = 5'd4; v.uses_rt = 1'b1;
    cyc(v, "loaduse_rt", HZ, ALL, 1, 0);
    v.uses_rt = 1'b0;
    cyc(v, "rt_not_used", IDLE, ALL, 2, 0);

    // register 0 never hazards
    v = idle_vec(); v.idex_mr = 1'b1; v.idex_rw = 1'b1; v.idex_d = 5'd0; v.br = 1'b1;
    v.ex_mr = 1'b1; v.ex_d = 5'd0; v.uses_rt = 1'b1;
    cyc(v, "dst_zero", IDLE, ALL, 2, 0);

    // lw $5 ; beq $5,$0 : rule (b) then (c), then flush
    v = idle_vec(); v.idex_rw = 1'b1; v.idex_mr = 1'b1; v.idex_d = 5'd5;
    v.br = 1'b1; v.rs = 5'd5; v.uses_rt = 1'b1; v.taken = 1'b1;
    cyc(v, "branch_stall_b", HZ, ALL, 2, 0);
    v = idle_vec(); v.ex_mr = 1'b1; v.ex_d = 5'd5; v.br = 1'b1; v.rs = 5'd5; v.uses_rt = 1'b1; v.taken = 1'b1;
    cyc(v, "branch_stall_c", HZ, ALL, 3, 0);
    v = idle_vec(); v.br = 1'b1; v.rs = 5'd5; v.uses_rt = 1'b1; v.taken = 1'b1;
    cyc(v, "branch_flush", FLUSH, ALL, 4, 0);
    cyc(idle_vec(), "after_flush", IDLE, ALL, 4, 1);

    // ALU producer feeds a branch; same producer without a branch is forwarded
    v = idle_vec(); v.br = 1'b1; v.rs = 5'd7; v.idex_rw = 1'b1; v.idex_d = 5'd7;
    cyc(v, "alu_to_branch", HZ, ALL, 4, 1);
    v.br = 1'b0;
    cyc(v, "alu_no_branch", IDLE, ALL, 5, 1);
    v = idle_vec(); v.rs = 5'd5; v.ex_mr = 1'b1; v.ex_d = 5'd5;
    cyc(v, "exmem_load_no_branch", IDLE, ALL, 5, 1);

    // three-cycle memory freeze; branch and load-use suppressed
    v = idle_vec(); v.memacc = 1'b1; v.rdy = 1'b0;
    cyc(v, "freeze_1", FRZ, ALL, 5, 1);
    v.taken = 1'b1;
    cyc(v, "freeze_2_taken", FRZ, ALL, 6, 1);
    v.taken = 1'b0; v.idex_mr = 1'b1; v.idex_d = 5'd3; v.rs = 5'd3;
    cyc(v, "freeze_3_hz", FRZ, ALL, 7, 1);
    v = idle_vec(); v.memacc = 1'b1; v.rdy = 1'b1; v.taken = 1'b1;
    cyc(v, "freeze_release", FLUSH, ALL, 8, 1);
    cyc(idle_vec(), "after_release", IDLE, ALL, 8, 2);

    // watchdog with MEM_TIMEOUT=4
    v = idle_vec(); v.memacc = 1'b1; v.rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(v, $sformatf("wait_%0d", i + 1), FRZ, ALL, 8 + i, 2);
    cyc(v, "wait_5", FRZ, NO_TO, 12, 2);
    cyc(v, "wait_6_timeout", FRZ | 6'b000001, ALL, 13, 2);
    v = idle_vec();
    cyc(v, "timeout_sticky_release", IDLE | 6'b000001, ALL, 14, 2);
    cyc(v, "timeout_sticky_idle", IDLE | 6'b000001, ALL, 14, 2);

    // stall counter saturates at 15
    v = idle_vec(); v.memacc = 1'b1; v.rdy = 1'b0;
    cyc(v, "sat_a", FRZ | 6'b000001, ALL, 14, 2);
    cyc(v, "sat_b", FRZ | 6'b000001, ALL, 15, 2);
    cyc(v, "sat_c", FRZ | 6'b000001, ALL, 15, 2);

    // asynchronous reset mid-wait
    v.rst = 1'b0;
    cyc(v, "reset_mid_wait", IDLE, ALL, 0, 0);
    cyc(idle_vec(), "post_reset", IDLE, ALL, 0, 0);
    v = idle_vec(); v.memacc = 1'b1; v.rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(v, $sformatf("fresh_wait_%0d", i + 1), FRZ, ALL, i, 0);
    cyc(idle_vec(), "fresh_release", IDLE, ALL, 3, 0);

    @(negedge clock);
    #1;
    checks++;
    if (fq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", fq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
